// File: rtl/reset_sequencer_pkg.sv
// rtl/reset_sequencer_pkg.sv - shared halt-bus and sequencer state definitions
//
// Purpose : the definitions that the common header carries, plus the typed
//           state enum built from them.
//           HALTBUSWIDTH / HALT_SIM : halt bus width and the bit this block drives.
//           RSEQ_*                  : sequencer state encodings.
// Ports   : none (package).
`ifndef RESET_SEQUENCER_COMMON_VH
`define RESET_SEQUENCER_COMMON_VH
`define HALTBUSWIDTH  2
`define HALT_SIM      0
`define RSEQ_HOLD     2'd0
`define RSEQ_HALT_REL 2'd1
`define RSEQ_RST_REL  2'd2
`define RSEQ_RUN      2'd3
`endif

package reset_sequencer_pkg;

  localparam int HALT_BUS_W  = `HALTBUSWIDTH;
  localparam int HALT_SIM_IX = `HALT_SIM;

  typedef enum logic [1:0] {
    ST_HOLD     = `RSEQ_HOLD,
    ST_HALT_REL = `RSEQ_HALT_REL,
    ST_RST_REL  = `RSEQ_RST_REL,
    ST_RUN      = `RSEQ_RUN
  } rseq_state_e;

endpackage

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - multi-stage flop synchronizer with async reset value
//
// Purpose : brings an asynchronous level into the clk domain.
// Ports   : clk_i  - destination clock
//           rst_i  - asynchronous active-high reset, loads RESET_VAL
//           d_i    - asynchronous input level
//           q_o    - synchronized level, STAGES edges behind d_i
module sync_ff #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] chain_q;
  logic [STAGES-1:0] chain_d;

  assign chain_d = {chain_q[STAGES-2:0], d_i};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      chain_q <= {STAGES{RESET_VAL}};
    end else begin
      chain_q <= chain_d;
    end
  end

  assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - staged halt/reset release sequencer with restart
//
// Purpose : holds the core halted and all reset domains asserted after reset
//           or a restart request, then releases halt, then each domain in
//           turn on fixed cycle thresholds.
// Ports   : clk         - clock
//           reset       - asynchronous active-high reset
//           sw_req      - synchronous one-cycle restart request
//           ext_req_n   - asynchronous active-low restart button (level)
//           halt_out    - 1 while the core is halted
//           reset_n_out - per-domain active-low resets
//           busy        - 1 until the last domain is released
//           done        - one-cycle pulse on the edge the last domain releases
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int HALT_CYCLES  = 40,
  parameter int RESET_CYCLES = 50,
  parameter int NCHAN        = 1,
  parameter int STAGGER      = 0,
  parameter int SYNC_STAGES  = 2,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sw_req,
  input  logic             ext_req_n,
  output logic             halt_out,
  output logic [NCHAN-1:0] reset_n_out,
  output logic             busy,
  output logic             done
);

  localparam int LAST_CYCLE = RESET_CYCLES + (NCHAN - 1) * STAGGER;

  localparam logic [CNT_W-1:0] HALT_TH  = CNT_W'(HALT_CYCLES);
  localparam logic [CNT_W-1:0] RESET_TH = CNT_W'(RESET_CYCLES);
  localparam logic [CNT_W-1:0] LAST_TH  = CNT_W'(LAST_CYCLE);

  if (longint'(LAST_CYCLE) > ((longint'(1) << CNT_W) - 1)) begin : g_cnt_w_chk
    $error("reset_sequencer: CNT_W too narrow for the release schedule");
  end
  if (RESET_CYCLES < HALT_CYCLES) begin : g_order_chk
    $error("reset_sequencer: RESET_CYCLES must be >= HALT_CYCLES");
  end
  if (NCHAN < 1 || NCHAN > 16) begin : g_nchan_chk
    $error("reset_sequencer: NCHAN must be 1..16");
  end
  if (SYNC_STAGES < 2) begin : g_sync_chk
    $error("reset_sequencer: SYNC_STAGES must be >= 2");
  end

  logic ext_sync_n;

  sync_ff #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_ext_sync (
    .clk_i (clk),
    .rst_i (reset),
    .d_i   (ext_req_n),
    .q_o   (ext_sync_n)
  );

  logic req;
  assign req = sw_req | ~ext_sync_n;

  rseq_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             halt_q, halt_d;
  logic [NCHAN-1:0] rst_n_q, rst_n_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Every output is derived from the next count, so releases happen on the
  // very edge the count reaches its threshold.
  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    if (req) begin
      cnt_d   = '0;
      state_d = ST_HOLD;
    end else begin
      if (state_q != ST_RUN) begin
        cnt_d = cnt_q + 1'b1;
      end
      if (cnt_d >= LAST_TH) begin
        state_d = ST_RUN;
      end else if (cnt_d >= RESET_TH) begin
        state_d = ST_RST_REL;
      end else if (cnt_d >= HALT_TH) begin
        state_d = ST_HALT_REL;
      end else begin
        state_d = ST_HOLD;
      end
    end
    halt_d = req || (cnt_d < HALT_TH);
    busy_d = (state_d != ST_RUN);
    done_d = (state_d == ST_RUN) && (state_q != ST_RUN);
  end

  for (genvar ch = 0; ch < NCHAN; ch++) begin : g_chan
    localparam logic [CNT_W-1:0] CH_TH = CNT_W'(RESET_CYCLES + ch * STAGGER);
    assign rst_n_d[ch] = !req && (cnt_d >= CH_TH);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_HOLD;
      cnt_q   <= '0;
      halt_q  <= 1'b1;
      rst_n_q <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      halt_q  <= halt_d;
      rst_n_q <= rst_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign halt_out    = halt_q;
  assign reset_n_out = rst_n_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Synthesizable, parametrised power-on and re-run sequencer for the Tenyr core and its peripherals. Holds the core halted and every downstream reset domain in reset for a programmable number of cycles. It then releases halt first and the reset domains afterwards, in a staggered order. It also re-runs the whole sequence on a software pulse or an asynchronous external button. It sits between the board clock/reset pins and the `halt` bus / `reset_n` inputs of Tenyr and its peripheral domains, and replaces fixed-delay initial blocks with hardware that works in both simulation and on silicon.

## Interface
- `HALT_CYCLES`, 40: number of clock edges from sequence start until `halt_out` deasserts.
- `RESET_CYCLES`, 50: number of clock edges from sequence start until `reset_n_out[0]` deasserts; must be >= `HALT_CYCLES`.
- `NCHAN`, 1: number of reset domains, from 1 to 16.
- `STAGGER`, 0: extra edges between the release of consecutive channels.
- `SYNC_STAGES`, 2: synchronizer depth for `ext_req_n`, minimum 2.
- `CNT_W`, 8: counter width; must hold `RESET_CYCLES + (NCHAN-1)*STAGGER`. Violating this is an elaboration error.

- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high.
- `sw_req` in 1: synchronous single-cycle request to restart the sequence.
- `ext_req_n` in 1: asynchronous, active-low button; level-sensitive after synchronization.
- `halt_out` out 1: drives the `HALT_SIM` bit of the halt bus; 1 means halted.
- `reset_n_out` out NCHAN: per-domain active-low resets.
- `busy` out 1: 1 while the sequence is incomplete.
- `done` out 1: single-cycle pulse on the edge at which the last channel is released.

## Operation
- States: `HOLD` → `HALT_REL` → `RST_REL` → `RUN`. The encoding lives in the shared header.
- `HOLD`:
  - `halt_out`=1, all `reset_n_out`=0, `busy`=1.
  - `cnt` increments by 1 per edge.
- `HOLD` → `HALT_REL`: on the edge where `cnt` reaches `HALT_CYCLES`. On that edge `halt_out` is registered to 0.
- `HALT_REL` → `RST_REL`: on the edge where `cnt` reaches `RESET_CYCLES`. On that edge `reset_n_out[0]` is registered to 1.
- `RST_REL`: channel i is released on the edge where `cnt` reaches `RESET_CYCLES + i*STAGGER`.
- `RST_REL` → `RUN`: on the edge that releases channel `NCHAN-1`. On that edge `busy` goes to 0 and `done`=1 for one cycle.
- `RUN`: `cnt` holds its value; there is no wrap-around.
- Restart request = `sw_req` OR the synchronized, inverted `ext_req_n`. A request sampled on any edge, in any state, does all of the following on that edge:
  - `cnt`=0, state=`HOLD`.
  - `halt_out`=1, all `reset_n_out`=0, `busy`=1.
  - `done`=0, including when the request coincides with the edge that would have completed the sequence.
- While the synchronized `ext_req_n` stays low, the block stays in `HOLD` with `cnt`=0. Timing restarts on the first edge after the synchronized level goes high.
- Degenerate parameters:
  - `HALT_CYCLES == RESET_CYCLES`: halt and channel 0 are released on the same edge; `HALT_REL` lasts zero cycles.
  - `STAGGER=0`: all channels are released together with channel 0.
  - `NCHAN=1`: `RST_REL` and `RUN` are entered on the same edge.

## Timing
- Reset values (async, immediate): `halt_out`=1, `reset_n_out`=0, `busy`=1, `done`=0, `cnt`=0, state=`HOLD`. The synchronizer flops reset to 1 (no request).
- All outputs are registered with no combinational input-to-output paths.
- `reset` deasserted and first edge counted as edge 1: `halt_out` is low after edge `HALT_CYCLES` and `reset_n_out[i]` is high after edge `RESET_CYCLES + i*STAGGER`.
- `sw_req` latency: outputs return to their held values on the same edge `sw_req` is sampled.
- `ext_req_n` latency: `SYNC_STAGES` edges to sync, then 1 edge to act.
- Asserting `reset` mid-sequence forces the reset values immediately; counting restarts from edge 1 after release.

## Structure
- Shared header `common.vh` carries:
  - `HALTBUSWIDTH` and `HALT_SIM`;
  - new state-encoding `define`s `RSEQ_HOLD`, `RSEQ_HALT_REL`, `RSEQ_RST_REL`, `RSEQ_RUN`.
- Sub-module `sync_ff`: `SYNC_STAGES`-deep flop chain with asynchronous reset to a parameterised value. It is reused by other domain crossings.
- Per-channel release is one comparator per channel against a constant threshold, generated with a generate loop.

## Test plan
- Defaults, release `reset` at t0 → `halt_out` falls after edge 40, `reset_n_out[0]` rises after edge 50, `done` pulses on edge 50, `busy`=0 from then on.
- `NCHAN=4`, `STAGGER=3`, `RESET_CYCLES=50` → channels rise after edges 50, 53, 56, 59; `done` is only on edge 59; `cnt` holds at 59 while in `RUN`.
- In `RUN`, pulse `sw_req` for 1 cycle → on that edge `halt_out`=1 and all `reset_n_out`=0; the release schedule repeats, measured 40/50 edges from that edge.
- Hold `ext_req_n` low for 100 cycles, starting mid-`HALT_REL` → `halt_out` reasserts 3 edges after the fall (with `SYNC_STAGES`=2) and stays high for the whole low time. Release falls 40 edges after the synchronized rise.
- `sw_req` on the edge that would release channel 0 → no `done` pulse, channel 0 stays 0, and the sequence restarts.
- `HALT_CYCLES=RESET_CYCLES=10` → `halt_out` falls and `reset_n_out[0]` rises on the same edge, 10; assert `reset` on edge 5 of a rerun → outputs take reset values immediately.
